pattern_chain_pipe: RTL
=======================

# pattern_chain_pipe

Parametrised successor to the merged two-pattern netlist blocks. It chains `DEPTH` registered pattern stages over a `WIDTH`-bit datapath. Each word is transformed at every stage by a per-word mode: pass, NOR-rotate, NAND-history or XOR-history. It adds a valid/ready handshake with full backpressure, an output-transfer counter, and an optional MISR signature. It sits between pattern sources and the capture/compare logic of the grammar test fabric.

## Interface
Parameters:
- `WIDTH`, default 8: datapath width; must be ≥ 2.
- `DEPTH`, default 4: number of pattern stages; must be ≥ 1.
- `CNT_W`, default 16: width of the transfer counter.

Ports:
- `blif_clk_net`, in, 1: the single clock.
- `blif_reset_net`, in, 1: reset; synchronous, active-low.
- `in_valid`, in, 1: input word present.
- `in_ready`, out, 1: stage 0 can capture.
- `in_data`, in, `WIDTH`: input word.
- `in_mode`, in, 2: 0 PASS, 1 NOR, 2 NAND, 3 XOR; the mode travels with the word.
- `out_valid`, out, 1: last stage holds a word.
- `out_ready`, in, 1: downstream accepts.
- `out_data`, out, `WIDTH`: last-stage data.
- `out_g42`, out, 1: NOR-reduction of `out_data`; meaningful only while `out_valid` is 1.
- `word_cnt`, out, `CNT_W`: count of output transfers.
- `misr`, out, `WIDTH`: output signature (see Configuration).

## Operation
- Each stage k holds:
  - `v_k`: valid bit.
  - `d_k`: data.
  - `m_k`: mode.
  - `h_k`: history, the last data value stage k captured.
- Stage k captures whenever its input is valid and `adv_k` is true. The input of stage 0 is `in_*`; the input of stage k>0 is stage k-1.
  - `adv_k` = !`v_k` || `adv_{k+1}`.
  - `adv_DEPTH` = `out_ready`.
  - Bubbles collapse.
- Captured data is f(mode, x, `h_k`):
  - PASS: x.
  - NOR: ~(x | ror1(x)), where ror1 rotates right by 1, so bit i becomes bit i+1 and the MSB takes bit 0.
  - NAND: ~(x & `h_k`).
  - XOR: x ^ `h_k`.
- On every capture, `h_k` ← the captured data.
- `h_k` is never updated without a capture, so stalls preserve history.
- `in_ready` = `adv_0` while out of reset; it is forced to 0 while `blif_reset_net` is 0.
- Output transfer = `out_valid` && `out_ready`.
- `word_cnt` increments by 1 on each output transfer and saturates at 2^`CNT_W`−1.
- All arithmetic is modulo `WIDTH` bits except the saturating counter.

## Timing
- Latency: a word accepted at edge t is presented on `out_data` after edge t+`DEPTH`−1 when no stalls occur, and it transfers at edge t+`DEPTH`−1+… as soon as `out_ready` is 1.
- Throughput is 1 word per cycle with `out_ready` held at 1.
- Full pipeline with a simultaneous output transfer: the input is accepted in the same cycle (`in_ready` = 1).
- Full pipeline with `out_ready` = 0: `in_ready` = 0. No word is lost or duplicated, and `out_data` is held stable.
- Reset values, applied on a clock edge with `blif_reset_net` = 0:
  - all `v_k`, `d_k`, `m_k` and `h_k` are 0;
  - `out_valid` = 0, `out_data` = 0, `out_g42` = 1;
  - `word_cnt` = 0, `misr` = 0, `in_ready` = 0.
- Reset mid-stream flushes every stage and clears history; in-flight words are discarded.
- `in_ready` rises in the first cycle after reset is released.
- `in_data` and `in_mode` are sampled only when `in_valid` && `in_ready`.

## Configuration
- `PATTERN_CHAIN_MISR_EN` defined: on each output transfer, `misr` ← rol1(`misr`) ^ `out_data`, where rol1 rotates left by 1.
- `PATTERN_CHAIN_MISR_EN` undefined: `misr` is a constant 0, no signature registers are built, and the port remains present.

## Test plan
Default parameters unless noted (`WIDTH`=8, `DEPTH`=4).
- Reset: hold `blif_reset_net` at 0 for 3 cycles → `out_valid`=0, `out_data`=0x00, `out_g42`=1, `word_cnt`=0, `misr`=0, `in_ready`=0. Release → `in_ready`=1 on the next cycle.
- PASS latency: send 0xA5 in mode 0 with `out_ready`=1 → `out_valid` rises 4 cycles later with `out_data`=0xA5, `out_g42`=0, then `word_cnt`=1.
- NOR chain: send 0x00 in mode 1 → the stages produce 0xFF, 0x00, 0xFF, 0x00 → output 0x00 with `out_g42`=1.
- XOR history: after reset, send 0x3C in mode 3 twice → first output 0x3C. Second word: stage0 0x00, stage1 0x3C, stage2 0x00, stage3 0x3C → output 0x3C.
- Backpressure: with `out_ready`=0, offer 5 words 0x01–0x05 in mode 0 → exactly 4 are accepted, then `in_ready`=0 while `in_valid` is held. Raise `out_ready` → outputs 0x01–0x05 appear in order with no gaps after the first and no duplicates.
- Counter and MISR: with `CNT_W`=4 and the macro defined, send 17 PASS words → `word_cnt`=15. Separately, after reset, send 0x01 then 0x02 → `misr`=0x01, then 0x00. With the macro undefined, `misr` stays 0.

Source files
------------

// File: rtl/pattern_chain_pipe_if.sv
// rtl/pattern_chain_pipe_if.sv - valid/ready word bundle feeding and draining pattern_chain_pipe
// The master drives words in and accepts them out; the slave is the pipe itself.
interface pattern_chain_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_g42;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_g42
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_g42
  );
endinterface

// File: rtl/pattern_chain_pipe.sv
// rtl/pattern_chain_pipe.sv - DEPTH registered pattern stages (PASS/NOR/NAND/XOR) with backpressure
// Optional MISR signature over output transfers when PATTERN_CHAIN_MISR_EN is defined.
module pattern_chain_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               blif_clk_net,
  input  logic               blif_reset_net,
  pattern_chain_pipe_if.slave pc,
  output logic [CNT_W-1:0]   word_cnt,
  output logic [WIDTH-1:0]   misr
);
  typedef logic [WIDTH-1:0] word_t;

  logic       v_q   [DEPTH];
  logic       v_d   [DEPTH];
  word_t      d_q   [DEPTH];
  word_t      d_d   [DEPTH];
  logic [1:0] m_q   [DEPTH];
  logic [1:0] m_d   [DEPTH];
  logic       src_v [DEPTH];
  word_t      src_d [DEPTH];
  logic [1:0] src_m [DEPTH];
  logic [DEPTH:0]   adv;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             xfer;
  logic             unused_mode;

  function automatic word_t pattern_fn(input logic [1:0] mode, input word_t x, input word_t h);
    word_t r;
    case (mode)
      2'd0:    r = x;
      2'd1:    r = ~(x | {x[0], x[WIDTH-1:1]});
      2'd2:    r = ~(x & h);
      default: r = x ^ h;
    endcase
    return r;
  endfunction

  assign xfer = v_q[DEPTH-1] && pc.out_ready;

  // A stage's data register is written only on capture, so it is also that stage's history.
  always_comb begin
    adv[DEPTH] = pc.out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k] = !v_q[k] || adv[k+1];
    end

    src_v[0] = pc.in_valid;
    src_d[0] = pc.in_data;
    src_m[0] = pc.in_mode;
    for (int k = 1; k < DEPTH; k++) begin
      src_v[k] = v_q[k-1];
      src_d[k] = d_q[k-1];
      src_m[k] = m_q[k-1];
    end

    for (int k = 0; k < DEPTH; k++) begin
      v_d[k] = v_q[k];
      d_d[k] = d_q[k];
      m_d[k] = m_q[k];
      if (adv[k]) begin
        v_d[k] = src_v[k];
        if (src_v[k]) begin
          d_d[k] = pattern_fn(src_m[k], src_d[k], d_q[k]);
          m_d[k] = src_m[k];
        end
      end
    end

    cnt_d = cnt_q;
    if (xfer && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge blif_clk_net) begin
    if (!blif_reset_net) begin
      for (int k = 0; k < DEPTH; k++) begin
        v_q[k] <= 1'b0;
        d_q[k] <= '0;
        m_q[k] <= 2'd0;
      end
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        v_q[k] <= v_d[k];
        d_q[k] <= d_d[k];
        m_q[k] <= m_d[k];
      end
      cnt_q <= cnt_d;
    end
  end

  // The last stage's mode has no consumer.
  assign unused_mode = ^m_q[DEPTH-1];

  assign pc.in_ready  = adv[0] && blif_reset_net;
  assign pc.out_valid = v_q[DEPTH-1];
  assign pc.out_data  = d_q[DEPTH-1];
  assign pc.out_g42   = ~|d_q[DEPTH-1];
  assign word_cnt     = cnt_q;

`ifdef PATTERN_CHAIN_MISR_EN
  word_t misr_q, misr_d;

  always_comb begin
    misr_d = misr_q;
    if (xfer) begin
      misr_d = {misr_q[WIDTH-2:0], misr_q[WIDTH-1]} ^ d_q[DEPTH-1];
    end
  end

  always_ff @(posedge blif_clk_net) begin
    if (!blif_reset_net) begin
      misr_q <= '0;
    end else begin
      misr_q <= misr_d;
    end
  end

  assign misr = misr_q;
`else
  assign misr = '0;
`endif
endmodule
